// File: rtl/div_operand_sequencer.sv
// Operand sweep sequencer for the approximate/accurate divider pair.
// Issues in-domain (i, j) pairs one at a time and tallies comparator verdicts.
module div_operand_sequencer #(
    parameter int LAT    = 2,
    parameter int I_MIN  = 1,
    parameter int I_MAX  = 255,
    parameter int J_MIN  = 0,
    parameter int J_MAX  = 65535,
    parameter int J_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  i_out,
    output logic [15:0] j_out,
    output logic        op_valid,
    input  logic [15:0] err_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [15:0] skip_cnt,
    output logic [7:0]  first_fail_i,
    output logic [15:0] first_fail_j,
    output logic        first_fail_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SAMPLE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]  r_i;
    logic [15:0] r_j;
    logic [3:0]  r_wcnt;
    logic [7:0]  r_iout;
    logic [15:0] r_jout;
    logic [15:0] r_pass;
    logic [15:0] r_fail;
    logic [15:0] r_skip;
    logic [7:0]  r_ffi;
    logic [15:0] r_ffj;
    logic        r_ffv;

    logic [15:0] w_prod;
    logic        w_in_dom;
    logic [16:0] w_jn;
    logic        w_jn_ok;
    logic        w_clear;
    logic        w_issue;
    logic        w_skip;
    logic        w_pass;
    logic        w_fail;
    logic        w_dec;
    logic        w_step_j;
    logic        w_step_i;
    logic        w_unused_err;

    // 255*i as (i<<8)-i: at most 65025, so 16 bits never overflow
    assign w_prod   = {r_i, 8'h00} - {8'h00, r_i};
    assign w_in_dom = (r_j >= {8'h00, r_i}) && (r_j <= w_prod);

    // Bit 16 of the sum catches the wrap past 16'hFFFF
    assign w_jn    = {1'b0, r_j} + 17'(J_STEP);
    assign w_jn_ok = (w_jn <= 17'(J_MAX));

    assign w_unused_err = ^err_in[15:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_issue  = 1'b0;
        w_skip   = 1'b0;
        w_pass   = 1'b0;
        w_fail   = 1'b0;
        w_dec    = 1'b0;
        w_step_j = 1'b0;
        w_step_i = 1'b0;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_clear = 1'b1;
                        w_next  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_in_dom) begin
                        w_issue = 1'b1;
                        w_next  = (LAT == 1) ? S_SAMPLE : S_WAIT;
                    end else begin
                        w_skip = 1'b1;
                        w_next = S_ADVANCE;
                    end
                end
                S_WAIT: begin
                    w_dec = 1'b1;
                    if (r_wcnt <= 4'd1) begin
                        w_next = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    w_fail = err_in[0];
                    w_pass = ~err_in[0];
                    w_next = S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (w_jn_ok) begin
                        w_step_j = 1'b1;
                        w_next   = S_ISSUE;
                    end else if (r_i == 8'(I_MAX)) begin
                        w_next = S_DONE;
                    end else begin
                        w_step_i = 1'b1;
                        w_next   = S_ISSUE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i    <= 8'(I_MIN);
            r_j    <= 16'(J_MIN);
            r_wcnt <= '0;
            r_iout <= '0;
            r_jout <= '0;
            r_pass <= '0;
            r_fail <= '0;
            r_skip <= '0;
            r_ffi  <= '0;
            r_ffj  <= '0;
            r_ffv  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_i    <= 8'(I_MIN);
                r_j    <= 16'(J_MIN);
                r_pass <= '0;
                r_fail <= '0;
                r_skip <= '0;
                r_ffi  <= '0;
                r_ffj  <= '0;
                r_ffv  <= 1'b0;
            end
            if (w_issue) begin
                r_iout <= r_i;
                r_jout <= r_j;
                r_wcnt <= 4'(LAT - 1);
            end
            if (w_dec) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_skip && (r_skip != 16'hFFFF)) begin
                r_skip <= r_skip + 16'd1;
            end
            if (w_pass && (r_pass != 16'hFFFF)) begin
                r_pass <= r_pass + 16'd1;
            end
            if (w_fail && (r_fail != 16'hFFFF)) begin
                r_fail <= r_fail + 16'd1;
            end
            if (w_fail && !r_ffv) begin
                r_ffi <= r_iout;
                r_ffj <= r_jout;
                r_ffv <= 1'b1;
            end
            if (w_step_j) begin
                r_j <= w_jn[15:0];
            end
            if (w_step_i) begin
                r_i <= r_i + 8'd1;
                r_j <= 16'(J_MIN);
            end
        end
    end

    // The pair shows on the bus in the same cycle as its op_valid pulse
    assign op_valid = w_issue;
    assign i_out    = w_issue ? r_i : r_iout;
    assign j_out    = w_issue ? r_j : r_jout;

    assign busy = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                  (r_state == S_SAMPLE) || (r_state == S_ADVANCE);
    assign done = (r_state == S_DONE);

    assign pass_cnt       = r_pass;
    assign fail_cnt       = r_fail;
    assign skip_cnt       = r_skip;
    assign first_fail_i   = r_ffi;
    assign first_fail_j   = r_ffj;
    assign first_fail_vld = r_ffv;

endmodule
